hwpe_tcdm_port_arbiter: RTL and testbench
=========================================

// Module: hwpe_tcdm_port_arbiter
// PURPOSE
//  Upstream feeder for the cluster TCDM interconnect: merges N_IN HWPE memory ports onto
//  one TCDM master port using round-robin arbitration. Tracks in-order outstanding
//  transactions in a source-index FIFO and routes each response to the port that issued it.
//  Instantiated only when HWPE_PRESENT = 1.
// PARAMETERS
//  N_IN      default N_HWPE_PORTS (2)  number of HWPE-side ports, >= 1
//  AW        default 32                address width
//  DW        default 32                data width (BE width = DW/8)
//  MAX_OUTST default 4                 max in-flight transactions (power of 2, >= 2)
// PORTS
//  clk_i          in   1         clock
//  rst_i          in   1         reset (sync, active-high)
//  in_req_i       in   N_IN      per-port request
//  in_gnt_o       out  N_IN      per-port grant
//  in_add_i       in   N_IN*AW   per-port address
//  in_wen_i       in   N_IN      per-port write-enable (1 = read, 0 = write)
//  in_be_i        in   N_IN*DW/8 per-port byte enables
//  in_data_i      in   N_IN*DW   per-port write data
//  in_r_valid_o   out  N_IN      per-port response valid
//  in_r_data_o    out  N_IN*DW   per-port read data (broadcast; qualify with in_r_valid_o)
//  out_req_o      out  1         TCDM request
//  out_gnt_i      in   1         TCDM grant
//  out_add_o/out_wen_o/out_be_o/out_data_o  out  AW/1/DW/8/DW  muxed request fields
//  out_r_valid_i  in   1         TCDM response valid (in order, >= 1 cycle after grant)
//  out_r_data_i   in   DW        TCDM read data
//  busy_o         out  1         high while any transaction is outstanding
// BEHAVIOUR
//  - Clock clk_i, single domain; rst_i synchronous active-high.
//  - Reset: rr_ptr=0, FIFO empty, busy_o=0, in_r_valid_o=0; request path is combinational, so
//    out_req_o=0 and in_gnt_o=0 whenever no in_req_i is high or FIFO is full.
//  - Arbitration (comb.): winner = first i with in_req_i[i] scanning from rr_ptr upward, mod N_IN.
//    out_req_o = |in_req_i & !fifo_full; out_* fields = winner's fields.
//  - Handshake: in_gnt_o[winner] = out_gnt_i & out_req_o; losers see gnt=0 and hold request.
//    Zero-cycle request-to-grant latency; no registers in the request path.
//  - On a grant to port i: push i into FIFO; rr_ptr <= (i+1) mod N_IN. No grant -> rr_ptr holds.
//  - Every granted transaction (read or write) returns exactly one out_r_valid_i.
//  - On out_r_valid_i: pop FIFO head h; in_r_valid_o[h]=1 same cycle (comb.), others 0.
//  - Full: FIFO count == MAX_OUTST -> out_req_o forced 0 (no same-cycle push-on-pop when full).
//  - Simultaneous push and pop (not full): count unchanged, both take effect.
//  - Empty FIFO with out_r_valid_i=1: protocol error; response dropped, SVA assertion fires.
//  - Pointer/count wrap modulo MAX_OUTST; busy_o = (count != 0), registered view of count.
//  - Reset mid-operation: FIFO flushed, in-flight responses discarded; downstream reset together.
//  - N_IN == 1: arbiter degenerates to pass-through, FIFO still tracks outstanding count.
// CONFIGURATION
//  HWPE_ARB_PERF_CNT_EN defined: adds ports perf_clr_i (in,1), perf_gnt_cnt_o (out,N_IN*32),
//  perf_stall_cnt_o (out,N_IN*32). gnt_cnt[i]++ per grant to i; stall_cnt[i]++ per cycle with
//  in_req_i[i]=1 & in_gnt_o[i]=0. 32-bit saturating, cleared by rst_i or perf_clr_i (clear wins
//  over increment). Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package pulp_cluster_hwpe_pkg gains: hwpe_tcdm_req_t (add, wen, be, data),
//    hwpe_tcdm_rsp_t (r_valid, r_data), HWPE_ARB_MAX_OUTST localparam; N_HWPE_PORTS reused.
//  - Sub-module hwpe_arb_src_fifo: sync FIFO, width $clog2(N_IN) (min 1), depth MAX_OUTST,
//    push/pop/full/empty/count; arbiter and routing logic stay in the top.
// TESTING
//  1 Reset: hold rst_i 3 cycles with all in_req_i=1 -> out_req_o=0 during reset, busy_o=0 after.
//  2 Both ports req, out_gnt_i=1 continuous -> grants alternate 0,1,0,1; each port 2 of 4.
//  3 Port0 read 0x100, port1 read 0x104, responses 0xAAAA,0xBBBB 2 cycles later -> port0 gets
//    0xAAAA, port1 gets 0xBBBB, in order; busy_o falls after last response.
//  4 out_r_valid_i held 0, 4 grants -> 5th request sees out_req_o=0; one response -> resumes.
//  5 Grant and response in same cycle at count=2 -> count stays 2, correct port routed.
//  6 With HWPE_ARB_PERF_CNT_EN: port1 stalled 3 cycles, then granted -> stall_cnt[1]=3,
//    gnt_cnt[1]=1; perf_clr_i pulse -> all counters 0 next cycle.

Source files
------------

// File: rtl/pulp_cluster_hwpe_pkg.sv
// Shared HWPE cluster definitions: port count, TCDM request/response records, arbiter depth.
// Pure declarations; no timing or backpressure of its own.
package pulp_cluster_hwpe_pkg;

   localparam int unsigned N_HWPE_PORTS       = 2;
   localparam int unsigned HWPE_ARB_MAX_OUTST = 4;
   localparam int unsigned HWPE_TCDM_AW       = 32;
   localparam int unsigned HWPE_TCDM_DW       = 32;

   typedef struct packed {
      logic [HWPE_TCDM_AW-1:0]   add;
      logic                      wen;
      logic [HWPE_TCDM_DW/8-1:0] be;
      logic [HWPE_TCDM_DW-1:0]   data;
   } hwpe_tcdm_req_t;

   typedef struct packed {
      logic                    r_valid;
      logic [HWPE_TCDM_DW-1:0] r_data;
   } hwpe_tcdm_rsp_t;

   // Width of an index into n items; never zero so single-port builds stay legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hwpe_arb_src_fifo.sv
// Sync FIFO of issuing-port indices, one entry per in-flight TCDM transaction.
// Latency: push visible at head next cycle; pop is combinational on the head. Push ignored when full.
module hwpe_arb_src_fifo #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & ~empty_o;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/hwpe_tcdm_port_arbiter.sv
// Round-robin merge of N_IN HWPE ports onto one TCDM port; in-order response routing.
// Latency: zero-cycle request/grant, responses routed combinationally; stalls all ports at MAX_OUTST in flight.
// Optional perf counters under HWPE_ARB_PERF_CNT_EN.
module hwpe_tcdm_port_arbiter
   import pulp_cluster_hwpe_pkg::*;
#(
   parameter int unsigned N_IN      = N_HWPE_PORTS,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_OUTST = HWPE_ARB_MAX_OUTST
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_IN-1:0]       in_req_i,
   output logic [N_IN-1:0]       in_gnt_o,
   input  logic [N_IN*AW-1:0]    in_add_i,
   input  logic [N_IN-1:0]       in_wen_i,
   input  logic [N_IN*DW/8-1:0]  in_be_i,
   input  logic [N_IN*DW-1:0]    in_data_i,
   output logic [N_IN-1:0]       in_r_valid_o,
   output logic [N_IN*DW-1:0]    in_r_data_o,
   output logic                  out_req_o,
   input  logic                  out_gnt_i,
   output logic [AW-1:0]         out_add_o,
   output logic                  out_wen_o,
   output logic [DW/8-1:0]       out_be_o,
   output logic [DW-1:0]         out_data_o,
   input  logic                  out_r_valid_i,
   input  logic [DW-1:0]         out_r_data_i,
`ifdef HWPE_ARB_PERF_CNT_EN
   input  logic                  perf_clr_i,
   output logic [N_IN*32-1:0]    perf_gnt_cnt_o,
   output logic [N_IN*32-1:0]    perf_stall_cnt_o,
`endif
   output logic                  busy_o
);

   localparam int unsigned IW = idx_width(N_IN);
   localparam int unsigned BW = DW / 8;
   localparam int unsigned CW = $clog2(MAX_OUTST) + 1;

   typedef struct packed {
      logic [AW-1:0] add;
      logic          wen;
      logic [BW-1:0] be;
      logic [DW-1:0] data;
   } req_t;

   req_t          win_req;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d, winner, fifo_head;
   logic [IW:0]   cand;
   logic          found, grant, pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_cnt;

   // Requests are masked while in reset so nothing is pushed into a FIFO being flushed.
   assign out_req_o = (|in_req_i) & ~fifo_full & ~rst_i;
   assign grant     = out_req_o & out_gnt_i;
   assign pop       = out_r_valid_i & ~fifo_empty & ~rst_i;
   assign busy_o    = (fifo_cnt != '0);

   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < N_IN; k++) begin
         cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(N_IN)) begin
            cand = cand - (IW+1)'(N_IN);
         end
         if (!found && in_req_i[cand[IW-1:0]]) begin
            found  = 1'b1;
            winner = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      win_req = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (winner == IW'(i)) begin
            win_req.add  = in_add_i[i*AW +: AW];
            win_req.wen  = in_wen_i[i];
            win_req.be   = in_be_i[i*BW +: BW];
            win_req.data = in_data_i[i*DW +: DW];
         end
      end
   end

   assign out_add_o  = win_req.add;
   assign out_wen_o  = win_req.wen;
   assign out_be_o   = win_req.be;
   assign out_data_o = win_req.data;

   always_comb begin
      in_gnt_o     = '0;
      in_r_valid_o = '0;
      for (int i = 0; i < N_IN; i++) begin
         in_gnt_o[i]     = grant && (winner == IW'(i));
         in_r_valid_o[i] = pop && (fifo_head == IW'(i));
      end
   end

   assign in_r_data_o = {N_IN{out_r_data_i}};

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = ({1'b0, winner} == (IW+1)'(N_IN - 1)) ? '0 : IW'(winner + 1'b1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   hwpe_arb_src_fifo #(
      .WIDTH (IW),
      .DEPTH (MAX_OUTST)
   ) i_src_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (grant),
      .data_i  (winner),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   resp_without_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
      !(out_r_valid_i && fifo_empty));

`ifdef HWPE_ARB_PERF_CNT_EN
   logic [N_IN-1:0][31:0] gnt_cnt_q, gnt_cnt_d, stall_cnt_q, stall_cnt_d;

   always_comb begin
      gnt_cnt_d   = gnt_cnt_q;
      stall_cnt_d = stall_cnt_q;
      for (int i = 0; i < N_IN; i++) begin
         if (perf_clr_i) begin
            gnt_cnt_d[i]   = '0;
            stall_cnt_d[i] = '0;
         end else begin
            if (in_gnt_o[i] && (gnt_cnt_q[i] != '1)) begin
               gnt_cnt_d[i] = gnt_cnt_q[i] + 1'b1;
            end
            if (in_req_i[i] && !in_gnt_o[i] && (stall_cnt_q[i] != '1)) begin
               stall_cnt_d[i] = stall_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         gnt_cnt_q   <= gnt_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_gnt_cnt_o   = gnt_cnt_q;
   assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hwpe_tcdm_port_arbiter.sv
// Bench for hwpe_tcdm_port_arbiter: reset, vector table, corner sequences, random vs. queue model.
module tb_hwpe_tcdm_port_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     in_req_i = '0;
   logic [N-1:0]     in_gnt_o;
   logic [N*AW-1:0]  in_add_i = '0;
   logic [N-1:0]     in_wen_i = '0;
   logic [N*DW/8-1:0] in_be_i = '0;
   logic [N*DW-1:0]  in_data_i = '0;
   logic [N-1:0]     in_r_valid_o;
   logic [N*DW-1:0]  in_r_data_o;
   logic             out_req_o;
   logic             out_gnt_i = 1'b0;
   logic [AW-1:0]    out_add_o;
   logic             out_wen_o;
   logic [DW/8-1:0]  out_be_o;
   logic [DW-1:0]    out_data_o;
   logic             out_r_valid_i = 1'b0;
   logic [DW-1:0]    out_r_data_i = '0;
   logic             busy_o;
`ifdef HWPE_ARB_PERF_CNT_EN
   logic             perf_clr = 1'b0;
   logic [N*32-1:0]  perf_gnt;
   logic [N*32-1:0]  perf_stall;
`endif

   always #5 clk = ~clk;

   hwpe_tcdm_port_arbiter #(.N_IN(N), .AW(AW), .DW(DW), .MAX_OUTST(MO)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
      .in_be_i(in_be_i), .in_data_i(in_data_i), .in_r_valid_o(in_r_valid_o),
      .in_r_data_o(in_r_data_o), .out_req_o(out_req_o), .out_gnt_i(out_gnt_i),
      .out_add_o(out_add_o), .out_wen_o(out_wen_o), .out_be_o(out_be_o),
      .out_data_o(out_data_o), .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
`ifdef HWPE_ARB_PERF_CNT_EN
      .perf_clr_i(perf_clr), .perf_gnt_cnt_o(perf_gnt), .perf_stall_cnt_o(perf_stall),
`endif
      .busy_o(busy_o)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [1:0] req, input logic g, input logic rv, input logic [31:0] rd);
      in_req_i      = req;
      out_gnt_i     = g;
      out_r_valid_i = rv;
      out_r_data_i  = rd;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  req;
      logic        g;
      logic        rv;
      logic [31:0] rdata;
      logic        exp_oreq;
      logic [1:0]  exp_gnt;
      logic [1:0]  exp_rv;
      logic        exp_busy;
   } vec_t;

   vec_t tbl [13];

   // Behavioural model state: queue of issuing ports, round-robin start index.
   int q[$];
   int rr;

   initial begin
      tbl[0]  = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 1'b0};
      tbl[1]  = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 1'b1};
      tbl[2]  = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b1, 2'b01, 2'b00, 1'b1};
      tbl[3]  = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b1, 2'b10, 2'b00, 1'b1};
      tbl[4]  = '{2'b11, 1'b1, 1'b0, 32'h0,    1'b0, 2'b00, 2'b00, 1'b1};
      tbl[5]  = '{2'b11, 1'b1, 1'b1, 32'hAAAA, 1'b0, 2'b00, 2'b01, 1'b1};
      tbl[6]  = '{2'b11, 1'b1, 1'b1, 32'hBBBB, 1'b1, 2'b01, 2'b10, 1'b1};
      tbl[7]  = '{2'b10, 1'b0, 1'b0, 32'h0,    1'b1, 2'b00, 2'b00, 1'b1};
      tbl[8]  = '{2'b10, 1'b1, 1'b1, 32'h1111, 1'b1, 2'b10, 2'b01, 1'b1};
      tbl[9]  = '{2'b00, 1'b0, 1'b1, 32'h2222, 1'b0, 2'b00, 2'b10, 1'b1};
      tbl[10] = '{2'b00, 1'b0, 1'b1, 32'h3333, 1'b0, 2'b00, 2'b01, 1'b1};
      tbl[11] = '{2'b00, 1'b0, 1'b1, 32'h4444, 1'b0, 2'b00, 2'b10, 1'b1};
      tbl[12] = '{2'b00, 1'b0, 1'b0, 32'h0,    1'b0, 2'b00, 2'b00, 1'b0};

      // Reset held with both ports requesting.
      for (int c = 0; c < 3; c++) begin
         set_in(2'b11, 1'b1, 1'b0, 32'h0);
         chk("rst_out_req", 64'(out_req_o), 64'(0));
         chk("rst_in_gnt", 64'(in_gnt_o), 64'(0));
         step();
      end
      rst = 1'b0;
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      chk("post_rst_busy", 64'(busy_o), 64'(0));
      chk("post_rst_rvalid", 64'(in_r_valid_o), 64'(0));
      chk("post_rst_out_req", 64'(out_req_o), 64'(0));
      step();

      // Vector table: alternation, full stall, push-while-full blocked, drain.
      in_add_i  = {32'h104, 32'h100};
      in_wen_i  = 2'b11;
      in_be_i   = 8'hFF;
      in_data_i = '0;
      for (int r = 0; r < 13; r++) begin
         set_in(tbl[r].req, tbl[r].g, tbl[r].rv, tbl[r].rdata);
         chk($sformatf("tbl%0d_out_req", r), 64'(out_req_o), 64'(tbl[r].exp_oreq));
         chk($sformatf("tbl%0d_gnt", r), 64'(in_gnt_o), 64'(tbl[r].exp_gnt));
         chk($sformatf("tbl%0d_rvalid", r), 64'(in_r_valid_o), 64'(tbl[r].exp_rv));
         chk($sformatf("tbl%0d_busy", r), 64'(busy_o), 64'(tbl[r].exp_busy));
         if (tbl[r].exp_gnt != 2'b00)
            chk($sformatf("tbl%0d_add", r), 64'(out_add_o), tbl[r].exp_gnt[1] ? 64'h104 : 64'h100);
         if (tbl[r].exp_rv != 2'b00)
            chk($sformatf("tbl%0d_rdata", r),
                64'(tbl[r].exp_rv[1] ? in_r_data_o[63:32] : in_r_data_o[31:0]), 64'(tbl[r].rdata));
         step();
      end

      // Two reads, responses two cycles after each grant.
      do_reset();
      set_in(2'b11, 1'b1, 1'b0, 32'h0);
      chk("rd_gnt0", 64'(in_gnt_o), 64'(2'b01));
      chk("rd_add0", 64'(out_add_o), 64'h100);
      chk("rd_wen0", 64'(out_wen_o), 64'(1));
      step();
      set_in(2'b10, 1'b1, 1'b0, 32'h0);
      chk("rd_gnt1", 64'(in_gnt_o), 64'(2'b10));
      chk("rd_add1", 64'(out_add_o), 64'h104);
      step();
      set_in(2'b00, 1'b0, 1'b1, 32'hAAAA);
      chk("rd_rv0", 64'(in_r_valid_o), 64'(2'b01));
      chk("rd_data0", 64'(in_r_data_o[31:0]), 64'hAAAA);
      step();
      set_in(2'b00, 1'b0, 1'b1, 32'hBBBB);
      chk("rd_rv1", 64'(in_r_valid_o), 64'(2'b10));
      chk("rd_data1", 64'(in_r_data_o[63:32]), 64'hBBBB);
      chk("rd_busy_last", 64'(busy_o), 64'(1));
      step();
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      chk("rd_busy_done", 64'(busy_o), 64'(0));
      step();

      // Grant and response in the same cycle with two outstanding.
      do_reset();
      set_in(2'b01, 1'b1, 1'b0, 32'h0); step();
      set_in(2'b10, 1'b1, 1'b0, 32'h0); step();
      set_in(2'b01, 1'b1, 1'b1, 32'hC5);
      chk("pp_gnt", 64'(in_gnt_o), 64'(2'b01));
      chk("pp_rv", 64'(in_r_valid_o), 64'(2'b01));
      step();
      set_in(2'b00, 1'b0, 1'b1, 32'hC6);
      chk("pp_rv_a", 64'(in_r_valid_o), 64'(2'b10));
      step();
      set_in(2'b00, 1'b0, 1'b1, 32'hC7);
      chk("pp_rv_b", 64'(in_r_valid_o), 64'(2'b01));
      chk("pp_busy_b", 64'(busy_o), 64'(1));
      step();
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      chk("pp_busy_end", 64'(busy_o), 64'(0));
      step();

      // Random traffic against the queue model.
      do_reset();
      q.delete();
      rr = 0;
      for (int c = 0; c < 400; c++) begin
         logic [1:0] req;
         logic       g, rv, exp_oreq;
         logic [1:0] exp_gnt, exp_rv;
         int         w;
         req = 2'($urandom_range(0, 3));
         g   = ($urandom_range(0, 3) != 0);
         rv  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         in_add_i  = {$urandom, $urandom};
         in_wen_i  = 2'($urandom_range(0, 3));
         in_be_i   = 8'($urandom);
         in_data_i = {$urandom, $urandom};
         set_in(req, g, rv, $urandom);
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && req[(rr + k) % N]) w = (rr + k) % N;
         exp_oreq = (req != 0) && (q.size() < MO);
         exp_gnt  = (exp_oreq && g) ? 2'(1 << w) : 2'b00;
         exp_rv   = rv ? 2'(1 << q[0]) : 2'b00;
         chk("rnd_out_req", 64'(out_req_o), 64'(exp_oreq));
         chk("rnd_gnt", 64'(in_gnt_o), 64'(exp_gnt));
         chk("rnd_rvalid", 64'(in_r_valid_o), 64'(exp_rv));
         chk("rnd_busy", 64'(busy_o), 64'(q.size() != 0));
         if (exp_oreq) begin
            chk("rnd_add", 64'(out_add_o), 64'(in_add_i[w*AW +: AW]));
            chk("rnd_wen", 64'(out_wen_o), 64'(in_wen_i[w]));
            chk("rnd_be", 64'(out_be_o), 64'(in_be_i[w*4 +: 4]));
            chk("rnd_data", 64'(out_data_o), 64'(in_data_i[w*DW +: DW]));
         end
         if (rv) chk("rnd_rdata", 64'(in_r_data_o[q[0]*DW +: DW]), 64'(out_r_data_i));
         if (rv) void'(q.pop_front());
         if (exp_gnt != 2'b00) begin
            q.push_back(w);
            rr = (w + 1) % N;
         end
         step();
      end

`ifdef HWPE_ARB_PERF_CNT_EN
      do_reset();
      for (int c = 0; c < 3; c++) begin
         set_in(2'b10, 1'b0, 1'b0, 32'h0);
         step();
      end
      set_in(2'b10, 1'b1, 1'b0, 32'h0);
      step();
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      chk("perf_stall1", 64'(perf_stall[63:32]), 64'(3));
      chk("perf_gnt1", 64'(perf_gnt[63:32]), 64'(1));
      chk("perf_gnt0", 64'(perf_gnt[31:0]), 64'(0));
      perf_clr = 1'b1;
      step();
      perf_clr = 1'b0;
      #1;
      chk("perf_clr_gnt", 64'(perf_gnt), 64'(0));
      chk("perf_clr_stall", 64'(perf_stall), 64'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
